// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache requests onto one memory port with a single
// outstanding transaction, a post-writeback dcache lock and a response timeout.
module cache_mem_arbiter #(
    parameter int BLK_SIZE = 128,
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 1024,
    parameter int LOCK_WIN = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    input  logic                ic_req_uncached_i,
    output logic                ic_req_ready_o,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_data_o,

    input  logic                dc_req_valid_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_rw_i,
    input  logic [1:0]          dc_req_rw_size_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    input  logic                dc_req_uncached_i,
    output logic                dc_req_ready_o,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_data_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_rw_o,
    output logic [1:0]          mem_req_rw_size_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    output logic                mem_req_uncached_o,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_data_i,
    output logic                err_o
);
    // state | meaning
    // IDLE  | arbitrate; combinational ready pulse to the granted requester
    // ISSUE | present latched request to memory until accepted
    // WAIT  | wait for the memory response or the timeout
    // RESP  | one-cycle response pulse to the transaction owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LW = (LOCK_WIN < 8) ? 3 : $clog2(LOCK_WIN + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LW-1:0] LOCK_LAST = LW'((LOCK_WIN > 0) ? LOCK_WIN - 1 : 0);

    state_t              state;
    logic                prio_ic;
    logic                lock;
    logic [LW-1:0]       idle_cnt;
    logic [TW-1:0]       wait_cnt;
    logic                owner_dc;
    logic [XLEN-1:0]     addr_q;
    logic                rw_q;
    logic [1:0]          size_q;
    logic [BLK_SIZE-1:0] data_q;
    logic                unc_q;
    logic [BLK_SIZE-1:0] res_q;
    logic                ic_res_q;
    logic                dc_res_q;
    logic                err_q;

    logic idle_ok, ic_win, grant_ic, grant_dc, timed_out;

    always_comb begin
        idle_ok   = (state == IDLE) && !rst_i;
        ic_win    = ic_req_valid_i && !lock && (!dc_req_valid_i || prio_ic);
        grant_ic  = idle_ok && ic_win;
        grant_dc  = idle_ok && dc_req_valid_i && !ic_win;
        timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            prio_ic  <= 1'b1;
            lock     <= 1'b0;
            idle_cnt <= '0;
            wait_cnt <= '0;
            owner_dc <= 1'b0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            size_q   <= '0;
            data_q   <= '0;
            unc_q    <= 1'b0;
            res_q    <= '0;
            ic_res_q <= 1'b0;
            dc_res_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ic_res_q <= 1'b0;
            dc_res_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock && !dc_req_valid_i) begin
                        if (idle_cnt >= LOCK_LAST) begin
                            lock     <= 1'b0;
                            idle_cnt <= '0;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                    if (grant_ic || grant_dc) begin
                        state    <= ISSUE;
                        wait_cnt <= '0;
                        owner_dc <= grant_dc;
                        prio_ic  <= grant_dc;
                        if (grant_ic) begin
                            addr_q <= ic_req_addr_i;
                            rw_q   <= 1'b0;
                            size_q <= 2'b00;
                            data_q <= '0;
                            unc_q  <= ic_req_uncached_i;
                        end else begin
                            addr_q <= dc_req_addr_i;
                            rw_q   <= dc_req_rw_i;
                            size_q <= dc_req_rw_size_i;
                            data_q <= dc_req_data_i;
                            unc_q  <= dc_req_uncached_i;
                            if (!dc_req_rw_i) lock <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (timed_out) begin
                        state    <= RESP;
                        res_q    <= '0;
                        err_q    <= 1'b1;
                        ic_res_q <= !owner_dc;
                        dc_res_q <= owner_dc;
                    end else if (mem_req_ready_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A real response in the final cycle beats the timeout.
                    if (mem_res_valid_i) begin
                        state    <= RESP;
                        res_q    <= mem_res_data_i;
                        ic_res_q <= !owner_dc;
                        dc_res_q <= owner_dc;
                    end else if (timed_out) begin
                        state    <= RESP;
                        res_q    <= '0;
                        err_q    <= 1'b1;
                        ic_res_q <= !owner_dc;
                        dc_res_q <= owner_dc;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (owner_dc && rw_q) begin
                        lock     <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ic_req_ready_o     = grant_ic;
    assign dc_req_ready_o     = grant_dc;
    assign ic_res_valid_o     = ic_res_q;
    assign dc_res_valid_o     = dc_res_q;
    assign ic_res_data_o      = res_q;
    assign dc_res_data_o      = res_q;
    assign mem_req_valid_o    = (state == ISSUE);
    assign mem_req_addr_o     = addr_q;
    assign mem_req_rw_o       = rw_q;
    assign mem_req_rw_size_o  = size_q;
    assign mem_req_data_o     = data_q;
    assign mem_req_uncached_o = unc_q;
    assign err_o              = err_q;
endmodule
